// File: rtl/v4_peak_detector.sv
// v4_peak_detector: hysteresis pulse finder on the shaped stream; reports peak amplitude,
// peak timestamp and width through a one-entry valid/ready event register.
module v4_peak_detector #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_WIDTH = 32,
  parameter int W_WIDTH = 8,
  parameter int MIN_WIDTH = 3,
  parameter int HOLDOFF = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] input_bus,
  input  logic signed [SIZE_FILTER_DATA-1:0] thr_hi,
  input  logic signed [SIZE_FILTER_DATA-1:0] thr_lo,
  input  logic out_ready,
  output logic out_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] out_amplitude,
  output logic [TS_WIDTH-1:0] out_timestamp,
  output logic [W_WIDTH-1:0] out_width,
  output logic [15:0] drop_count,
  output logic busy
);
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;
  state_t state, state_n;
  logic signed [SIZE_FILTER_DATA-1:0] x_r, peak, peak_n, thr_eff_lo;
  logic [TS_WIDTH-1:0] ts, ts_r, peak_ts, peak_ts_n;
  logic [W_WIDTH-1:0] width, width_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic close, emit, hs;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ts <= '0;
      ts_r <= '0;
      x_r <= '0;
      state <= IDLE;
      peak <= '0;
      peak_ts <= '0;
      width <= '0;
      hold_cnt <= '0;
    end else begin
      ts <= ts + 1'b1;
      ts_r <= ts;
      x_r <= input_bus;
      state <= state_n;
      peak <= peak_n;
      peak_ts <= peak_ts_n;
      width <= width_n;
      hold_cnt <= hold_cnt_n;
    end
  // A release threshold above the arm threshold is clamped down to it.
  always_comb begin
    thr_eff_lo = (thr_lo > thr_hi) ? thr_hi : thr_lo;
    state_n = state;
    peak_n = peak;
    peak_ts_n = peak_ts;
    width_n = width;
    hold_cnt_n = hold_cnt;
    close = 1'b0;
    case (state)
      IDLE:
        if (x_r >= thr_hi) begin
          state_n = PULSE;
          peak_n = x_r;
          peak_ts_n = ts_r;
          width_n = W_WIDTH'(1);
        end
      PULSE:
        if (x_r >= thr_eff_lo) begin
          width_n = &width ? width : width + 1'b1;
          if (x_r > peak) begin
            peak_n = x_r;
            peak_ts_n = ts_r;
          end
        end else begin
          close = 1'b1;
          state_n = HOLDOFF == 0 ? IDLE : HOLD;
          hold_cnt_n = '0;
        end
      HOLD:
        if (hold_cnt == HW'(HOLDOFF - 1)) state_n = IDLE;
        else hold_cnt_n = hold_cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    emit = close && (width >= W_WIDTH'(MIN_WIDTH));
    hs = out_valid && out_ready;
    busy = state != IDLE;
  end
  // A handshake in the emit cycle frees the slot, so the new event is taken, not dropped.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      out_amplitude <= '0;
      out_timestamp <= '0;
      out_width <= '0;
      drop_count <= '0;
    end else if (emit && (!out_valid || hs)) begin
      out_valid <= 1'b1;
      out_amplitude <= peak;
      out_timestamp <= peak_ts;
      out_width <= width;
    end else if (emit) begin
      drop_count <= &drop_count ? drop_count : drop_count + 1'b1;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_v4_peak_detector.sv
// tb_v4_peak_detector: directed scenarios plus randomized streams against an
// array-scanning reference model of pulse extraction and the event register.
module tb_v4_peak_detector;
  localparam int TSW = 5, WW = 4, MINW = 3, HOLD = 8, N = 400;
  logic clk = 1'b0, reset = 1'b1, out_ready = 1'b1;
  logic signed [15:0] input_bus = '0, thr_hi = 16'sd100, thr_lo = 16'sd50;
  logic out_valid, busy;
  logic signed [15:0] out_amplitude;
  logic [TSW-1:0] out_timestamp;
  logic [WW-1:0] out_width;
  logic [15:0] drop_count;
  int total = 0, bad = 0, n = 0;
  int s[N];
  bit rdy[N];
  string phase = "init";

  v4_peak_detector #(.SIZE_FILTER_DATA(16), .TS_WIDTH(TSW), .W_WIDTH(WW),
                     .MIN_WIDTH(MINW), .HOLDOFF(HOLD)) dut (
    .clk(clk), .reset(reset), .input_bus(input_bus), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .out_ready(out_ready), .out_valid(out_valid), .out_amplitude(out_amplitude),
    .out_timestamp(out_timestamp), .out_width(out_width), .drop_count(drop_count),
    .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s/%s got=%0d exp=%0d", phase, tag, got, exp);
    end
  endtask

  // Reset is raised mid-cycle so outputs must clear without a clock edge.
  task automatic do_reset;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_amp", out_amplitude, 0);
    check("rst_ts", out_timestamp, 0);
    check("rst_width", out_width, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_seq(input int q[$], input int pad);
    n = q.size() + pad;
    for (int k = 0; k < n; k++) begin
      s[k] = k < q.size() ? q[k] : 0;
      rdy[k] = 1'b1;
    end
  endtask

  // Scan the evaluated sample stream for pulses, then play the event register cycle by cycle.
  task automatic run;
    int ex[N], et[N], ea[N], ets[N], ew[N];
    bit em[N], eb[N];
    int hi, lo, i, m, pk, pt, a, t, w, d, wmax;
    bit v, hs;
    hi = thr_hi;
    lo = thr_lo;
    if (lo > hi) lo = hi;
    wmax = (1 << WW) - 1;
    for (int j = 0; j < n; j++) begin
      ex[j] = j == 0 ? 0 : s[j-1];
      et[j] = j == 0 ? 0 : (j - 1) % (1 << TSW);
      em[j] = 1'b0;
      eb[j] = 1'b0;
    end
    i = 0;
    while (i < n) begin
      if (ex[i] >= hi) begin
        m = i + 1;
        while (m < n && ex[m] >= lo) m++;
        for (int j = i; j < n && j < m + HOLD; j++) eb[j] = 1'b1;
        if (m >= n) break;
        pk = ex[i];
        pt = et[i];
        for (int j = i + 1; j < m; j++)
          if (ex[j] > pk) begin
            pk = ex[j];
            pt = et[j];
          end
        if (m - i >= MINW) begin
          em[m] = 1'b1;
          ea[m] = pk;
          ets[m] = pt;
          ew[m] = m - i > wmax ? wmax : m - i;
        end
        i = m + HOLD + 1;
      end else i++;
    end
    v = 1'b0;
    a = 0;
    t = 0;
    w = 0;
    d = 0;
    for (int k = 0; k < n; k++) begin
      input_bus = 16'(s[k]);
      out_ready = rdy[k];
      @(posedge clk);
      #1;
      hs = v && rdy[k];
      if (em[k]) begin
        if (!v || hs) begin
          v = 1'b1;
          a = ea[k];
          t = ets[k];
          w = ew[k];
        end else if (d < 65535) d++;
      end else if (hs) v = 1'b0;
      check("busy", busy, eb[k]);
      check("valid", out_valid, v);
      check("drop", drop_count, d);
      if (v) begin
        check("amp", out_amplitude, a);
        check("ts", out_timestamp, t);
        check("width", out_width, w);
      end
      @(negedge clk);
    end
  endtask

  task automatic directed(input string name, input int q[$], input int pad);
    phase = name;
    set_seq(q, pad);
    do_reset();
    run();
  endtask

  initial begin
    int q[$];
    int hi, loe, r, x;
    q = '{0, 60, 120, 200, 300, 250, 150, 40, 0};
    directed("triangle", q, 20);
    q = '{0, 150, 30, 0};
    directed("spike", q, 20);
    q = '{0, 200, 400, 400, 400, 10};
    directed("flat", q, 20);
    q = '{0, 60, 120, 200, 300, 250, 150, 40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
          0, 60, 120, 210, 310, 260, 150, 40, 0};
    phase = "backpressure";
    set_seq(q, 30);
    for (int k = 0; k < 45; k++) rdy[k] = 1'b0;
    do_reset();
    run();
    q = '{0, 120, 200};
    directed("mid_pulse", q, 0);
    q = '{150, 40, 0};
    directed("tail", q, 20);
    q = {};
    for (int k = 0; k < 40; k++) q.push_back(-32768);
    q = {q, '{0, 60, 120, 200, 300, 250, 150, 40, 0}};
    directed("wrap", q, 20);
    q = {};
    q.push_back(0);
    for (int k = 0; k < 20; k++) q.push_back(200);
    q.push_back(0);
    directed("width_sat", q, 20);
    thr_lo = 16'sd300;
    q = '{0, 150, 200, 120, 90, 0};
    directed("clamp", q, 20);
    for (int p = 0; p < 6; p++) begin
      phase = $sformatf("rand%0d", p);
      hi = $urandom_range(1, 200);
      thr_hi = 16'(hi);
      thr_lo = 16'($urandom_range(0, 250));
      loe = int'(thr_lo) > hi ? hi : int'(thr_lo);
      n = 300;
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 9);
        x = r == 0 ? hi : r == 1 ? hi - 1 : r == 2 ? loe : r == 3 ? loe - 1 :
            r == 4 && k > 0 ? s[k-1] : r == 5 ? -32768 : r == 6 ? 32767 :
            int'($urandom_range(0, 300)) - 50;
        s[k] = x;
        rdy[k] = p < 3 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 1) != 0;
      end
      do_reset();
      run();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
